rig_emulator: RTL and testbench
===============================

RIG_EMULATOR -- requirements
Module: rig_emulator

Interface
REQ-001 Parameter FG_PERIOD_CYC, default 2_000_000, fast-gate period in clocks (10 ms at 200 MHz).
REQ-002 Parameter FG_OPEN_CYC, default 20_000, fast-gate open width in clocks (100 us).
REQ-003 Parameter DET_DELAY_CYC, default 40, trigger-to-busy delay in clocks (200 ns).
REQ-004 Parameter DET_BUSY_CYC, default 1_280_000, detector busy width in clocks (6.4 ms).
REQ-005 Parameter WIRE_DELAY_CYC, default 200, detonation-to-wire delay in clocks.
REQ-006 Parameter WIRE_PULSE_CYC, default 100, wire-sensor pulse width in clocks.
REQ-007 clock  in  1  system clock; all logic on rising edge.
REQ-008 reset  in  1  reset, synchronous, active-high.
REQ-009 enable  in  1  runs the fast-gate generator when high.
REQ-010 output_trigger  in  1  trigger from experiment FSM; rising edge requests a detector readout.
REQ-011 detonation_signal  in  1  detonation command; rising edge starts wire-sensor response.
REQ-012 fg_signal  out  1  emulated fast-gate opto pulse train.
REQ-013 detector_ready  out  1  high when detector accepts a trigger.
REQ-014 wire_signal  out  1  emulated wire-sensor pulse.
REQ-015 trigger_count  out  16  accepted triggers, wraps 0xFFFF->0x0000.
REQ-016 missed_count  out  8  triggers ignored while busy, saturates at 0xFF.
REQ-017 det_state  out  2  detector FSM state: 0 READY, 1 DELAY, 2 BUSY.

Function
REQ-018 All outputs SHALL be registered; parameters SHALL satisfy each >=1 and FG_OPEN_CYC < FG_PERIOD_CYC (elaboration-time check fails otherwise).
REQ-019 FG generator SHALL hold a phase counter 0..FG_PERIOD_CYC-1, incrementing each cycle while enable=1 and wrapping to 0.
REQ-020 fg_signal SHALL be high exactly when enable=1 and phase counter < FG_OPEN_CYC, one cycle after the counter value is reached.
REQ-021 enable=0 SHALL clear the phase counter to 0 and drive fg_signal 0 next cycle; re-enable restarts with a full open window.
REQ-022 Rising edges SHALL be detected against a one-cycle delayed copy of each input; edge seen in cycle N is acted on at edge N+1.
REQ-023 Detector FSM READY: detector_ready=1; trigger edge -> DELAY, delay counter cleared, trigger_count+1.
REQ-024 DELAY: detector_ready stays 1; after DET_DELAY_CYC cycles in DELAY -> BUSY, detector_ready=0.
REQ-025 BUSY: detector_ready=0 for exactly DET_BUSY_CYC cycles, then READY with detector_ready=1.
REQ-026 Trigger edges in DELAY or BUSY SHALL be ignored for state and trigger_count, and SHALL increment missed_count (saturating).
REQ-027 Trigger edge in the same cycle BUSY->READY transitions SHALL be counted missed; the FSM accepts only edges sampled while in READY.
REQ-028 Wire FSM IDLE: wire_signal=0; detonation edge -> WAIT.
REQ-029 WAIT: after WIRE_DELAY_CYC cycles -> PULSE with wire_signal=1 for exactly WIRE_PULSE_CYC cycles, then IDLE.
REQ-030 Detonation edges in WAIT or PULSE SHALL be ignored, no counter effect.
REQ-031 Detector FSM, wire FSM and FG generator SHALL be independent; simultaneous events in one cycle are all serviced.
REQ-032 Internal counters SHALL be 32 bits wide; no overflow for legal parameters.

Reset
REQ-033 reset=1 SHALL on next edge set fg_signal=0, detector_ready=1, wire_signal=0, trigger_count=0, missed_count=0, det_state=0, both FSMs idle, phase counter 0.
REQ-034 Edge-detect delay registers SHALL reset to 1, so an input held high across reset release is not an edge.
REQ-035 reset asserted mid-operation (DELAY, BUSY, WAIT, PULSE) SHALL abort immediately with no residual pulse after release.

Verification (FG_PERIOD 10, FG_OPEN 3, DET_DELAY 4, DET_BUSY 8, WIRE_DELAY 5, WIRE_PULSE 2)
REQ-036 enable=1 for 40 cycles -> fg_signal high 3 cycles every 10, 4 pulses; enable=0 mid-pulse -> fg_signal 0 next cycle.
REQ-037 single output_trigger edge sampled cycle N -> det_state=1 from N+1, detector_ready=0 cycles N+5..N+12, 1 at N+13; trigger_count=1.
REQ-038 second trigger edge during BUSY and one at the BUSY->READY cycle -> missed_count=2, trigger_count=1; 300 busy triggers -> missed_count=0xFF.
REQ-039 detonation edge sampled cycle M -> wire_signal high cycles M+6..M+7 only; second edge at M+3 has no effect.
REQ-040 reset pulse during BUSY with output_trigger held high -> detector_ready=1 after reset, counts 0, no new trigger accepted until trigger falls and rises.

Source files
------------

// File: rtl/rig_emulator.sv
// Test-rig emulator: fast-gate pulse train, detector trigger/busy handshake and
// wire-sensor response to detonation, each running independently.
module rig_emulator #(
    parameter int FG_PERIOD_CYC  = 2_000_000,
    parameter int FG_OPEN_CYC    = 20_000,
    parameter int DET_DELAY_CYC  = 40,
    parameter int DET_BUSY_CYC   = 1_280_000,
    parameter int WIRE_DELAY_CYC = 200,
    parameter int WIRE_PULSE_CYC = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        output_trigger,
    input  logic        detonation_signal,
    output logic        fg_signal,
    output logic        detector_ready,
    output logic        wire_signal,
    output logic [15:0] trigger_count,
    output logic [7:0]  missed_count,
    output logic [1:0]  det_state
);

    if (FG_PERIOD_CYC < 1 || FG_OPEN_CYC < 1 || DET_DELAY_CYC < 1 || DET_BUSY_CYC < 1 ||
        WIRE_DELAY_CYC < 1 || WIRE_PULSE_CYC < 1 || FG_OPEN_CYC >= FG_PERIOD_CYC) begin : g_bad_params
        $error("rig_emulator: illegal parameter set");
    end

    localparam logic [31:0] FG_LAST   = 32'(FG_PERIOD_CYC - 1);
    localparam logic [31:0] FG_OPEN   = 32'(FG_OPEN_CYC);
    localparam logic [31:0] DLY_LAST  = 32'(DET_DELAY_CYC - 1);
    localparam logic [31:0] BUSY_LAST = 32'(DET_BUSY_CYC - 1);
    localparam logic [31:0] WD_LAST   = 32'(WIRE_DELAY_CYC - 1);
    localparam logic [31:0] WP_LAST   = 32'(WIRE_PULSE_CYC - 1);

    typedef enum logic [1:0] {DET_READY = 2'd0, DET_DELAY = 2'd1, DET_BUSY = 2'd2} det_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_PULSE = 2'd2} wire_e;

    logic        trig_dly_q, deto_dly_q;
    logic        trig_rise, deto_rise;
    logic [31:0] phase_q, phase_d;
    logic        fg_q, fg_d;
    det_e        det_q, det_d;
    logic [31:0] det_cnt_q, det_cnt_d;
    logic        ready_q, ready_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  mcnt_q, mcnt_d;
    wire_e       wst_q, wst_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic        wire_q, wire_d;

    // Delay copies reset high so a level held across reset release is not an edge.
    assign trig_rise = output_trigger & ~trig_dly_q;
    assign deto_rise = detonation_signal & ~deto_dly_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            trig_dly_q <= 1'b1;
            deto_dly_q <= 1'b1;
            phase_q    <= 32'd0;
            fg_q       <= 1'b0;
            det_q      <= DET_READY;
            det_cnt_q  <= 32'd0;
            ready_q    <= 1'b1;
            tcnt_q     <= 16'd0;
            mcnt_q     <= 8'd0;
            wst_q      <= W_IDLE;
            wcnt_q     <= 32'd0;
            wire_q     <= 1'b0;
        end else begin
            trig_dly_q <= output_trigger;
            deto_dly_q <= detonation_signal;
            phase_q    <= phase_d;
            fg_q       <= fg_d;
            det_q      <= det_d;
            det_cnt_q  <= det_cnt_d;
            ready_q    <= ready_d;
            tcnt_q     <= tcnt_d;
            mcnt_q     <= mcnt_d;
            wst_q      <= wst_d;
            wcnt_q     <= wcnt_d;
            wire_q     <= wire_d;
        end
    end

    always_comb begin
        phase_d = 32'd0;
        fg_d    = 1'b0;
        if (enable) begin
            phase_d = (phase_q == FG_LAST) ? 32'd0 : phase_q + 32'd1;
            fg_d    = (phase_q < FG_OPEN);
        end
    end

    // Detector next-state
    always_comb begin
        det_d     = det_q;
        det_cnt_d = det_cnt_q;
        case (det_q)
            DET_READY: if (trig_rise) begin
                det_d     = DET_DELAY;
                det_cnt_d = 32'd0;
            end
            DET_DELAY: if (det_cnt_q == DLY_LAST) begin
                det_d     = DET_BUSY;
                det_cnt_d = 32'd0;
            end else det_cnt_d = det_cnt_q + 32'd1;
            DET_BUSY: if (det_cnt_q == BUSY_LAST) begin
                det_d     = DET_READY;
                det_cnt_d = 32'd0;
            end else det_cnt_d = det_cnt_q + 32'd1;
            default: begin
                det_d     = DET_READY;
                det_cnt_d = 32'd0;
            end
        endcase
    end

    // Detector outputs; only edges sampled in READY are accepted
    always_comb begin
        ready_d = (det_d != DET_BUSY);
        tcnt_d  = tcnt_q;
        mcnt_d  = mcnt_q;
        if (trig_rise) begin
            if (det_q == DET_READY) tcnt_d = tcnt_q + 16'd1;
            else if (mcnt_q != 8'hFF) mcnt_d = mcnt_q + 8'd1;
        end
    end

    // Wire-sensor next-state
    always_comb begin
        wst_d  = wst_q;
        wcnt_d = wcnt_q;
        case (wst_q)
            W_IDLE: if (deto_rise) begin
                wst_d  = W_WAIT;
                wcnt_d = 32'd0;
            end
            W_WAIT: if (wcnt_q == WD_LAST) begin
                wst_d  = W_PULSE;
                wcnt_d = 32'd0;
            end else wcnt_d = wcnt_q + 32'd1;
            W_PULSE: if (wcnt_q == WP_LAST) begin
                wst_d  = W_IDLE;
                wcnt_d = 32'd0;
            end else wcnt_d = wcnt_q + 32'd1;
            default: begin
                wst_d  = W_IDLE;
                wcnt_d = 32'd0;
            end
        endcase
    end

    always_comb begin
        wire_d = (wst_d == W_PULSE);
    end

    assign fg_signal      = fg_q;
    assign detector_ready = ready_q;
    assign wire_signal    = wire_q;
    assign trigger_count  = tcnt_q;
    assign missed_count   = mcnt_q;
    assign det_state      = det_q;

endmodule

// File: tb/tb_rig_emulator.sv
// Bench for rig_emulator: directed scenarios plus random traffic, checked every
// cycle against a time-window model (acceptance times, not FSM states).
module tb_rig_emulator;
    localparam int FP = 10, FO = 3, DD = 4, DB = 8, WD = 5, WP = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        output_trigger = 1'b0;
    logic        detonation_signal = 1'b0;
    logic        fg_signal, detector_ready, wire_signal;
    logic [15:0] trigger_count;
    logic [7:0]  missed_count;
    logic [1:0]  det_state;

    rig_emulator #(
        .FG_PERIOD_CYC(FP), .FG_OPEN_CYC(FO), .DET_DELAY_CYC(DD),
        .DET_BUSY_CYC(DB), .WIRE_DELAY_CYC(WD), .WIRE_PULSE_CYC(WP)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .output_trigger(output_trigger), .detonation_signal(detonation_signal),
        .fg_signal(fg_signal), .detector_ready(detector_ready), .wire_signal(wire_signal),
        .trigger_count(trigger_count), .missed_count(missed_count), .det_state(det_state)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Model: cycle of last accepted trigger / detonation, start of enable run
    int          cur = 0;
    int          m_lacc = -1000, m_ldet = -1000, m_enst = 0;
    logic        m_ptrig = 1'b1, m_pdet = 1'b1, m_pen = 1'b0;
    logic [15:0] m_tc = 16'd0;
    int          m_mc = 0;
    logic        e_fg = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
        end
    endtask

    task automatic step(input logic rs, input logic en, input logic tr, input logic dt);
        int k, kw;
        logic [1:0] e_st;
        reset = rs; enable = en; output_trigger = tr; detonation_signal = dt;
        if (rs) begin
            m_lacc = -1000; m_ldet = -1000; m_tc = 16'd0; m_mc = 0;
            m_ptrig = 1'b1; m_pdet = 1'b1; m_pen = 1'b0; e_fg = 1'b0;
        end else begin
            if (tr && !m_ptrig) begin
                if (cur - m_lacc > DD + DB) begin
                    m_lacc = cur;
                    m_tc = m_tc + 16'd1;
                end else if (m_mc < 255) m_mc++;
            end
            if (dt && !m_pdet && (cur - m_ldet > WD + WP)) m_ldet = cur;
            if (en && !m_pen) m_enst = cur;
            e_fg = en && (((cur - m_enst) % FP) < FO);
            m_ptrig = tr; m_pdet = dt; m_pen = en;
        end
        @(posedge clock);
        #1;
        cur++;
        k  = cur - m_lacc;
        kw = cur - m_ldet;
        e_st = (k >= 1 && k <= DD) ? 2'd1 : (k > DD && k <= DD + DB) ? 2'd2 : 2'd0;
        chk("fg_signal", 16'(fg_signal), 16'(e_fg));
        chk("det_state", 16'(det_state), 16'(e_st));
        chk("detector_ready", 16'(detector_ready), 16'(e_st != 2'd2));
        chk("wire_signal", 16'(wire_signal), 16'(kw > WD && kw <= WD + WP));
        chk("trigger_count", trigger_count, m_tc);
        chk("missed_count", 16'(missed_count), 16'(m_mc));
    endtask

    initial begin
        logic [12:0] tpat;
        // reset state
        repeat (3) step(1, 0, 0, 0);
        // fast gate: 40 enabled cycles, then a short run cut mid-pulse
        repeat (40) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        // single trigger, held high a while
        repeat (4) step(0, 0, 1, 0);
        repeat (16) step(0, 0, 0, 0);
        // accepted edge, one during BUSY, one on the BUSY->READY cycle
        tpat = 13'b1_0000_1000_0001;
        for (int i = 0; i < 13; i++) step(0, 0, tpat[i], 0);
        repeat (16) step(0, 0, 0, 0);
        // toggled triggers until missed count saturates
        for (int i = 0; i < 700; i++) step(0, 0, i[0], 0);
        repeat (16) step(0, 0, 0, 0);
        // detonation with a second edge during WAIT
        step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 1);
        repeat (12) step(0, 0, 0, 0);
        // reset while BUSY with trigger held high
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (7) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        repeat (16) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        repeat (16) step(0, 0, 1, 0);
        // random traffic, occasional reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
